// File: rtl/module_result_out_if.sv
// rtl/module_result_out_if.sv - product-in / BCD-digit-out handshake bundle
interface module_result_out_if;
  logic        valid;
  logic [15:0] producto_i;
  logic        dat_ack;
  logic [3:0]  dato;
  logic        signo;
  logic        dat_ready;
  logic [19:0] bcd_o;
  logic        busy;
  logic        done;

  modport master (
    output valid, producto_i, dat_ack,
    input  dato, signo, dat_ready, bcd_o, busy, done
  );

  modport slave (
    input  valid, producto_i, dat_ack,
    output dato, signo, dat_ready, bcd_o, busy, done
  );
endinterface

// File: rtl/module_result_out.sv
// rtl/module_result_out.sv - signed product to five BCD digits, sent MSD first
module module_result_out (
  input  logic                  clk,
  input  logic                  rst,
  module_result_out_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, CONV, SEND, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] mag_q, mag_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [19:0] bcd_o_q, bcd_o_d;
  logic [3:0]  dato_q, dato_d;
  logic        signo_q, signo_d;
  logic        dat_ready_q, dat_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [19:0] adj;

  function automatic logic [3:0] nibble(input logic [19:0] v, input logic [2:0] i);
    case (i)
      3'd4:    nibble = v[19:16];
      3'd3:    nibble = v[15:12];
      3'd2:    nibble = v[11:8];
      3'd1:    nibble = v[7:4];
      default: nibble = v[3:0];
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcd_o_d = bcd_o_q;
    signo_d = signo_q;
    adj     = acc_q;
    for (int k = 0; k < 5; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          signo_d = bus.producto_i[15];
          // 0x8000 negates to itself, which is exactly 32768 read as unsigned
          mag_d   = bus.producto_i[15] ? (~bus.producto_i + 16'd1) : bus.producto_i;
          acc_d   = 20'd0;
          cnt_d   = 4'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = {adj[18:0], mag_q[15]};
        mag_d = {mag_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          bcd_o_d = {adj[18:0], mag_q[15]};
          idx_d   = 3'd4;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.dat_ack && dat_ready_q) begin
          if (idx_q == 3'd0) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the next state so a held ack yields one fresh digit per cycle
    busy_d      = (state_d != IDLE);
    dat_ready_d = (state_d == SEND);
    done_d      = (state_d == DONE);
    dato_d      = (state_d == SEND) ? nibble(bcd_o_d, idx_d) : 4'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mag_q       <= 16'd0;
      acc_q       <= 20'd0;
      cnt_q       <= 4'd0;
      idx_q       <= 3'd0;
      bcd_o_q     <= 20'd0;
      dato_q      <= 4'd0;
      signo_q     <= 1'b0;
      dat_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      bcd_o_q     <= bcd_o_d;
      dato_q      <= dato_d;
      signo_q     <= signo_d;
      dat_ready_q <= dat_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.dato      = dato_q;
  assign bus.signo     = signo_q;
  assign bus.dat_ready = dat_ready_q;
  assign bus.bcd_o     = bcd_o_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_module_result_out.sv
// tb/tb_module_result_out.sv - randomized bench with arithmetic decimal reference model
module tb_module_result_out;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  module_result_out_if bus ();

  module_result_out dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dato"}, 32'(bus.dato), 0);
    check({tag, "_signo"}, 32'(bus.signo), 0);
    check({tag, "_ready"}, 32'(bus.dat_ready), 0);
    check({tag, "_bcd"}, 32'(bus.bcd_o), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
  endtask

  // abort_after < 5 returns right after that many digits were acknowledged
  task automatic run_product(input logic [15:0] p, input int gap, input bit poke_valid,
                             input int abort_after);
    int          mag;
    int          t;
    logic [3:0]  dig [5];
    logic [19:0] eb;
    logic        neg;
    neg = p[15];
    mag = neg ? (65536 - int'(p)) : int'(p);
    t   = mag;
    eb  = '0;
    for (int i = 0; i < 5; i++) begin
      dig[i] = 4'(t % 10);
      t      = t / 10;
      eb     = eb | (20'(dig[i]) << (4 * i));
    end

    for (int w = 0; w < 40 && bus.busy; w++) step();
    check("idle_before_capture", 32'(bus.busy), 0);

    bus.producto_i = p;
    bus.valid      = 1'b1;
    step();
    bus.valid      = 1'b0;
    bus.producto_i = 16'($urandom);
    check("busy_after_capture", 32'(bus.busy), 1);
    check("signo_after_capture", 32'(bus.signo), 32'(neg));

    for (int k = 1; k < 16; k++) begin
      step();
      check("ready_during_conv", 32'(bus.dat_ready), 0);
    end
    step();
    check("ready_first_rise", 32'(bus.dat_ready), 1);
    check("bcd_o", 32'(bus.bcd_o), 32'(eb));
    check("signo", 32'(bus.signo), 32'(neg));

    for (int d = 4; d >= 0; d--) begin
      if (abort_after == 4 - d) return;
      for (int g = 0; g < gap; g++) begin
        check("dato_hold", 32'(bus.dato), 32'(dig[d]));
        if (poke_valid && g == 0) begin
          bus.valid      = 1'b1;
          bus.producto_i = 16'($urandom);
        end
        step();
        bus.valid = 1'b0;
      end
      check("dato", 32'(bus.dato), 32'(dig[d]));
      check("ready_in_send", 32'(bus.dat_ready), 1);
      bus.dat_ack = 1'b1;
      step();
      if (gap > 0 || d == 0) bus.dat_ack = 1'b0;
    end
    bus.dat_ack = 1'b0;
    check("done_pulse", 32'(bus.done), 1);
    check("ready_in_done", 32'(bus.dat_ready), 0);
    check("dato_in_done", 32'(bus.dato), 0);
    check("busy_in_done", 32'(bus.busy), 1);
    step();
    check("done_cleared", 32'(bus.done), 0);
    check("busy_idle", 32'(bus.busy), 0);
    check("bcd_o_held", 32'(bus.bcd_o), 32'(eb));
  endtask

  initial begin
    bus.valid      = 1'b0;
    bus.producto_i = 16'd0;
    bus.dat_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    run_product(16'h0031, 0, 1'b0, 5);
    run_product(16'hFFCF, 0, 1'b0, 5);
    run_product(16'h2649, 1, 1'b0, 5);
    run_product(16'h8000, 0, 1'b0, 5);
    run_product(16'h7FFF, 2, 1'b0, 5);
    run_product(16'h0000, 0, 1'b0, 5);
    run_product(16'h1234, 3, 1'b1, 5);
    run_product(16'hFFFF, 3, 1'b1, 5);

    run_product(16'hD8F1, 1, 1'b0, 2);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_in_send");
    @(negedge clk);
    rst = 1'b1;
    run_product(16'h0457, 0, 1'b0, 5);

    for (int n = 0; n < 20; n++) begin
      run_product(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
